// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch types and
// the sequential multiplier FSM states.
package cpu_pkg;

  typedef enum logic [3:0] {
    EXE_ADD = 4'b0000,
    EXE_SUB = 4'b0010,
    EXE_AND = 4'b0100,
    EXE_OR  = 4'b0101,
    EXE_NOR = 4'b0110,
    EXE_XOR = 4'b0111,
    EXE_SLL = 4'b1000,
    EXE_SRA = 4'b1001,
    EXE_SRL = 4'b1010,
    EXE_MUL = 4'b1100
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEZ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W
// bits of the unsigned product presented in the DONE cycle.
module seq_mul
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(MUL_ITER + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_ITER - 1);

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // busy_o also covers the IDLE cycle that accepts start, so the caller
  // freezes in the same cycle the multiply is detected.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          busy_o   = 1'b1;
          state_d  = MUL_BUSY;
          mcand_d  = mcand_i;
          mplier_d = mplier_i;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = MUL_IDLE;
        end
      end
      MUL_BUSY: begin
        busy_o   = 1'b1;
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = (cnt_q == LAST_STEP) ? MUL_DONE : MUL_BUSY;
      end
      MUL_DONE: begin
        done_o  = 1'b1;
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  assign product_o = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID/EXE register, inline ALU and branch resolution, EXE/MEM
// register, with a sequential multiplier that stalls the front end.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic [1:0]        mem_signal_in,
  input  logic [1:0]        branch_type_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [4:0]        dest_in,
  input  logic              flush_in,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr,
  output logic              stall,
  output logic              wb_en_out,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [4:0]        dest_out
);

  typedef struct packed {
    logic              wb;
    logic [1:0]        mem;
    logic [1:0]        br;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] pc;
    logic [4:0]        dest;
  } id_ex_t;

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic              mw;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [4:0]        dest;
  } ex_mem_t;

  id_ex_t            r1_q, r1_d;
  ex_mem_t           r2_q, r2_d;
  logic [DATA_W-1:0] alu_s;
  logic [4:0]        shamt_s;
  logic              br_taken_s;
  logic [DATA_W-1:0] br_addr_s;
  logic              mul_start_s, mul_busy_s, mul_done_s;
  logic [DATA_W-1:0] mul_prod_s;

  assign mul_start_s = r1_q.wb && (r1_q.cmd == EXE_MUL);
  assign stall       = mul_busy_s;

  seq_mul #(
    .DATA_W   (DATA_W),
    .MUL_ITER (MUL_ITER)
  ) u_seq_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start_s),
    .mcand_i   (r1_q.v1),
    .mplier_i  (r1_q.v2),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  // Stall freezes the whole instruction; a flush only strips its side effects.
  always_comb begin
    r1_d = r1_q;
    if (stall) begin
      r1_d = r1_q;
    end else begin
      r1_d.cmd  = exe_cmd_in;
      r1_d.v1   = val1_in;
      r1_d.v2   = val2_in;
      r1_d.r2   = reg2_in;
      r1_d.pc   = pc_in;
      r1_d.dest = dest_in;
      if (flush_in || br_taken_s) begin
        r1_d.wb  = 1'b0;
        r1_d.mem = 2'b00;
        r1_d.br  = 2'b00;
      end else begin
        r1_d.wb  = wb_en_in;
        r1_d.mem = mem_signal_in;
        r1_d.br  = branch_type_in;
      end
    end
  end

  assign shamt_s = r1_q.v2[4:0];

  always_comb begin
    alu_s = '0;
    case (r1_q.cmd)
      EXE_ADD: alu_s = r1_q.v1 + r1_q.v2;
      EXE_SUB: alu_s = r1_q.v1 - r1_q.v2;
      EXE_AND: alu_s = r1_q.v1 & r1_q.v2;
      EXE_OR:  alu_s = r1_q.v1 | r1_q.v2;
      EXE_NOR: alu_s = ~(r1_q.v1 | r1_q.v2);
      EXE_XOR: alu_s = r1_q.v1 ^ r1_q.v2;
      EXE_SLL: alu_s = r1_q.v1 << shamt_s;
      EXE_SRA: alu_s = DATA_W'($signed(r1_q.v1) >>> shamt_s);
      EXE_SRL: alu_s = r1_q.v1 >> shamt_s;
      EXE_MUL: alu_s = mul_done_s ? mul_prod_s : '0;
      default: alu_s = '0;
    endcase
  end

  always_comb begin
    br_taken_s = 1'b0;
    br_addr_s  = r1_q.pc + (r1_q.v2 << 2);
    case (r1_q.br)
      BR_BEZ:  br_taken_s = (r1_q.v1 == '0);
      BR_BNE:  br_taken_s = (r1_q.v1 != r1_q.r2);
      BR_JMP: begin
        br_taken_s = 1'b1;
        br_addr_s  = r1_q.v2;
      end
      default: br_taken_s = 1'b0;
    endcase
  end

  assign br_taken = br_taken_s;
  assign br_addr  = br_addr_s;

  // MEM sees bubbles for the whole multiply and the product in DONE.
  always_comb begin
    r2_d = '0;
    if (stall) begin
      r2_d = '0;
    end else begin
      r2_d.wb   = r1_q.wb;
      r2_d.mr   = r1_q.mem[1];
      r2_d.mw   = r1_q.mem[0];
      r2_d.alu  = alu_s;
      r2_d.st   = r1_q.r2;
      r2_d.dest = r1_q.dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q <= '0;
      r2_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
    end
  end

  assign wb_en_out  = r2_q.wb;
  assign mem_r_en   = r2_q.mr;
  assign mem_w_en   = r2_q.mw;
  assign alu_result = r2_q.alu;
  assign st_val     = r2_q.st;
  assign dest_out   = r2_q.dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: an instruction-level model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_exe_stage;

  localparam int STALL_LEN = 33;
  localparam logic [3:0] C_ADD = 4'b0000;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_AND = 4'b0100;
  localparam logic [3:0] C_OR  = 4'b0101;
  localparam logic [3:0] C_NOR = 4'b0110;
  localparam logic [3:0] C_XOR = 4'b0111;
  localparam logic [3:0] C_SLL = 4'b1000;
  localparam logic [3:0] C_SRA = 4'b1001;
  localparam logic [3:0] C_SRL = 4'b1010;
  localparam logic [3:0] C_MUL = 4'b1100;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in;
  logic [1:0]  mem_signal_in;
  logic [1:0]  branch_type_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val1_in, val2_in, reg2_in, pc_in;
  logic [4:0]  dest_in;
  logic        flush_in;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        stall;
  logic        wb_en_out, mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_val;
  logic [4:0]  dest_out;

  exe_stage #(.DATA_W(32), .MUL_ITER(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en_in       (wb_en_in),
    .mem_signal_in  (mem_signal_in),
    .branch_type_in (branch_type_in),
    .exe_cmd_in     (exe_cmd_in),
    .val1_in        (val1_in),
    .val2_in        (val2_in),
    .reg2_in        (reg2_in),
    .pc_in          (pc_in),
    .dest_in        (dest_in),
    .flush_in       (flush_in),
    .br_taken       (br_taken),
    .br_addr        (br_addr),
    .stall          (stall),
    .wb_en_out      (wb_en_out),
    .mem_r_en       (mem_r_en),
    .mem_w_en       (mem_w_en),
    .alu_result     (alu_result),
    .st_val         (st_val),
    .dest_out       (dest_out)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        wb;
    logic [1:0]  mem;
    logic [1:0]  br;
    logic [3:0]  cmd;
    logic [31:0] v1, v2, r2, pc;
    logic [4:0]  dest;
  } ins_t;

  typedef struct packed {
    logic        wb, mr, mw;
    logic [31:0] alu, st;
    logic [4:0]  dest;
  } res_t;

  // Model: instruction in EXE, result at MEM, stall cycles still owed.
  ins_t m_exe;
  res_t m_mem;
  int   m_left;
  logic chk_en;

  int n_pass = 0;
  int n_tot  = 0;

  // Literal expectations for the current cycle; mask bits:
  // 0 wb, 1 alu, 2 st, 3 dest, 4 stall, 5 br_taken, 6 br_addr, 7 stall run length
  logic [7:0]  lit_mask;
  string       lit_name;
  logic        lit_wb, lit_stall, lit_br;
  logic [31:0] lit_alu, lit_st, lit_addr;
  logic [4:0]  lit_dest;
  int          lit_run;

  function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_NOR:   return ~(a | b);
      C_XOR:   return a ^ b;
      C_SLL:   return a << b[4:0];
      C_SRA:   return 32'($signed(a) >>> b[4:0]);
      C_SRL:   return a >> b[4:0];
      C_MUL:   return 32'(64'(a) * 64'(b));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic taken_f(ins_t i);
    case (i.br)
      2'd1:    return i.v1 == 32'd0;
      2'd2:    return i.v1 != i.r2;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] addr_f(ins_t i);
    return (i.br == 2'd3) ? i.v2 : (i.pc + (i.v2 << 2));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    ins_t nx_exe;
    res_t nx_mem;
    int   nx_left;
    if (rst) begin
      nx_exe = '0;
      nx_mem = '0;
      nx_left = 0;
    end else if (m_left > 0) begin
      nx_exe = m_exe;
      nx_mem = '0;
      nx_left = m_left - 1;
    end else begin
      nx_mem = '{wb: m_exe.wb, mr: m_exe.mem[1], mw: m_exe.mem[0],
                 alu: alu_f(m_exe.cmd, m_exe.v1, m_exe.v2), st: m_exe.r2, dest: m_exe.dest};
      nx_exe = '{wb: wb_en_in, mem: mem_signal_in, br: branch_type_in, cmd: exe_cmd_in,
                 v1: val1_in, v2: val2_in, r2: reg2_in, pc: pc_in, dest: dest_in};
      if (flush_in || taken_f(m_exe)) begin
        nx_exe.wb  = 1'b0;
        nx_exe.mem = 2'b00;
        nx_exe.br  = 2'b00;
      end
      nx_left = (nx_exe.wb && nx_exe.cmd == C_MUL) ? STALL_LEN : 0;
    end
    @(posedge clk);
    m_exe = nx_exe;
    m_mem = nx_mem;
    m_left = nx_left;
    lit_mask = 8'd0;
    #1;
  endtask

  task automatic drive(input logic wb, input logic [1:0] mem, input logic [1:0] br,
                       input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] r2, input logic [31:0] pc, input logic [4:0] dest,
                       input logic fl);
    wb_en_in = wb; mem_signal_in = mem; branch_type_in = br; exe_cmd_in = cmd;
    val1_in = v1; val2_in = v2; reg2_in = r2; pc_in = pc; dest_in = dest; flush_in = fl;
  endtask

  task automatic nop();
    drive(1'b0, 2'd0, 2'd0, C_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic expect_res(input string name, input logic wb, input logic [31:0] alu,
                            input logic [31:0] st, input logic [4:0] dest);
    lit_name = name; lit_wb = wb; lit_alu = alu; lit_st = st; lit_dest = dest;
    lit_mask = lit_mask | 8'h0F;
  endtask

  task automatic expect_br(input string name, input logic tk, input logic [31:0] addr);
    lit_name = name; lit_br = tk; lit_addr = addr;
    lit_mask = lit_mask | (tk ? 8'h60 : 8'h20);
  endtask

  task automatic finish_mul();
    while (m_left > 0) tick();
    lit_name = "mul_stall_run"; lit_run = STALL_LEN; lit_mask = lit_mask | 8'h80;
  endtask

  // Single compare process: model every cycle, literals when requested.
  initial begin
    int run_cnt = 0;
    int last_run = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (stall) run_cnt++;
        else if (run_cnt != 0) begin last_run = run_cnt; run_cnt = 0; end
        chk("stall", 32'(stall), 32'(m_left > 0));
        chk("br_taken", 32'(br_taken), 32'(taken_f(m_exe)));
        if (m_exe.br != 2'd0) chk("br_addr", br_addr, addr_f(m_exe));
        chk("wb_en_out", 32'(wb_en_out), 32'(m_mem.wb));
        chk("mem_r_en", 32'(mem_r_en), 32'(m_mem.mr));
        chk("mem_w_en", 32'(mem_w_en), 32'(m_mem.mw));
        if (m_mem.wb || m_mem.mr || m_mem.mw) begin
          chk("alu_result", alu_result, m_mem.alu);
          chk("st_val", st_val, m_mem.st);
          chk("dest_out", 32'(dest_out), 32'(m_mem.dest));
        end
        if (lit_mask[0]) chk({lit_name, "/wb"}, 32'(wb_en_out), 32'(lit_wb));
        if (lit_mask[1]) chk({lit_name, "/alu"}, alu_result, lit_alu);
        if (lit_mask[2]) chk({lit_name, "/st"}, st_val, lit_st);
        if (lit_mask[3]) chk({lit_name, "/dest"}, 32'(dest_out), 32'(lit_dest));
        if (lit_mask[4]) chk({lit_name, "/stall"}, 32'(stall), 32'(lit_stall));
        if (lit_mask[5]) chk({lit_name, "/br_taken"}, 32'(br_taken), 32'(lit_br));
        if (lit_mask[6]) chk({lit_name, "/br_addr"}, br_addr, lit_addr);
        if (lit_mask[7]) chk({lit_name, "/len"}, 32'(last_run), 32'(lit_run));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  t_cmd [11];
    logic [31:0] t_v1  [11];
    logic [31:0] t_v2  [11];
    logic [31:0] t_exp [11];
    t_cmd = '{C_AND, C_OR, C_NOR, C_XOR, C_SLL, C_SRA, C_SRL, 4'b0011, 4'b1111, C_ADD, C_SUB};
    t_v1  = '{32'hF0F0_1234, 32'hF000_0000, 32'h0000_FFFF, 32'hAAAA_5555, 32'h0000_0001,
              32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'd10};
    t_v2  = '{32'h0FF0_FFFF, 32'h0000_000F, 32'h00FF_0000, 32'hFFFF_0000, 32'h0000_0023,
              32'd4, 32'd4, 32'd5, 32'd5, 32'd2, 32'd3};
    t_exp = '{32'h00F0_1234, 32'hF000_000F, 32'hFF00_0000, 32'h5555_5555, 32'h0000_0008,
              32'hF800_0000, 32'h0800_0000, 32'd0, 32'd0, 32'd1, 32'd7};

    chk_en = 1'b0; lit_mask = 8'd0; lit_name = "";
    m_exe = '0; m_mem = '0; m_left = 0;
    nop(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;
    expect_res("reset", 1'b0, 32'd0, 32'd0, 5'd0);
    lit_stall = 1'b0; lit_mask = lit_mask | 8'h10;
    expect_br("reset", 1'b0, 32'd0);

    // ADD and SUB wrap
    drive(1'b1, 2'd0, 2'd0, C_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b0); tick();
    nop(); tick();
    expect_res("add", 1'b1, 32'd12, 32'd0, 5'd3);
    drive(1'b1, 2'd0, 2'd0, C_SUB, 32'd0, 32'd1, 32'd0, 32'd0, 5'd4, 1'b0); tick();
    nop(); tick();
    expect_res("sub_wrap", 1'b1, 32'hFFFF_FFFF, 32'd0, 5'd4);

    // BNE taken flushes the wrong-path ADD
    drive(1'b0, 2'd0, 2'd2, C_ADD, 32'd4, 32'd3, 32'd5, 32'h100, 5'd0, 1'b0); tick();
    expect_br("bne", 1'b1, 32'h10C);
    drive(1'b1, 2'd0, 2'd0, C_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd7, 1'b0); tick();
    nop(); tick();
    lit_name = "bne_shadow"; lit_wb = 1'b0; lit_mask = lit_mask | 8'h01;

    // BEZ taken, BEZ not taken keeps the next instruction, JMP
    drive(1'b0, 2'd0, 2'd1, C_ADD, 32'd0, 32'd4, 32'd0, 32'h200, 5'd0, 1'b0); tick();
    expect_br("bez_taken", 1'b1, 32'h210);
    drive(1'b0, 2'd0, 2'd1, C_ADD, 32'd1, 32'd4, 32'd0, 32'h200, 5'd0, 1'b0); tick();
    expect_br("bez_not", 1'b0, 32'd0);
    drive(1'b1, 2'd0, 2'd0, C_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 5'd9, 1'b0); tick();
    nop(); tick();
    expect_res("after_bez_not", 1'b1, 32'd4, 32'd0, 5'd9);
    drive(1'b0, 2'd0, 2'd3, C_ADD, 32'd0, 32'h400, 32'd0, 32'h300, 5'd0, 1'b0); tick();
    expect_br("jmp", 1'b1, 32'h400);
    nop(); tick();

    // ALU table, issued back to back
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 2'd0, 2'd0, t_cmd[i], t_v1[i], t_v2[i], 32'(i * 17), 32'd0, 5'(10 + i), 1'b0);
      tick();
      if (i > 0) expect_res("alu_tab", 1'b1, t_exp[i-1], 32'((i - 1) * 17), 5'(9 + i));
    end
    nop(); tick();
    expect_res("alu_tab", 1'b1, t_exp[10], 32'(170), 5'd20);

    // Store and load control
    drive(1'b0, 2'b01, 2'd0, C_ADD, 32'h1000, 32'h20, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0); tick();
    drive(1'b1, 2'b10, 2'd0, C_ADD, 32'h2000, 32'h4, 32'd0, 32'd0, 5'd6, 1'b0); tick();
    expect_res("store", 1'b0, 32'h1020, 32'hDEAD_BEEF, 5'd0);
    nop(); tick();

    // MUL 6*7 with a following ADD held in ID
    drive(1'b1, 2'd0, 2'd0, C_MUL, 32'd6, 32'd7, 32'd0, 32'd0, 5'd5, 1'b0); tick();
    drive(1'b1, 2'd0, 2'd0, C_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd6, 1'b0);
    finish_mul();
    tick();
    expect_res("mul_6x7", 1'b1, 32'd42, 32'd0, 5'd5);
    nop(); tick();
    expect_res("add_after_mul", 1'b1, 32'd3, 32'd0, 5'd6);

    // Back-to-back MULs
    drive(1'b1, 2'd0, 2'd0, C_MUL, 32'd3, 32'd5, 32'd0, 32'd0, 5'd8, 1'b0); tick();
    drive(1'b1, 2'd0, 2'd0, C_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd9, 1'b0);
    finish_mul();
    tick();
    expect_res("mul_b2b_1", 1'b1, 32'd15, 32'd0, 5'd8);
    nop();
    finish_mul();
    tick();
    expect_res("mul_b2b_2", 1'b1, 32'hFFFF_FFFE, 32'd0, 5'd9);

    // MUL bubble must not start the multiplier
    drive(1'b0, 2'd0, 2'd0, C_MUL, 32'd6, 32'd7, 32'd0, 32'd0, 5'd5, 1'b0); tick();
    lit_name = "mul_bubble"; lit_stall = 1'b0; lit_mask = lit_mask | 8'h10;
    nop(); tick();

    // Reset in BUSY cycle 10 aborts the multiply
    drive(1'b1, 2'd0, 2'd0, C_MUL, 32'd9, 32'd9, 32'd0, 32'd0, 5'd12, 1'b0); tick();
    nop();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    lit_name = "mul_reset"; lit_stall = 1'b0; lit_wb = 1'b0; lit_mask = lit_mask | 8'h11;
    expect_br("mul_reset", 1'b0, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    lit_name = "mul_reset_quiet"; lit_wb = 1'b0; lit_mask = lit_mask | 8'h01;
    drive(1'b1, 2'd0, 2'd0, C_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 5'd1, 1'b0); tick();
    lit_name = "post_reset_idle"; lit_stall = 1'b0; lit_mask = lit_mask | 8'h10;
    nop(); tick();
    expect_res("post_reset_add", 1'b1, 32'd4, 32'd0, 5'd1);

    // Flush squashes an ADD; flush during stall leaves the MUL intact
    drive(1'b1, 2'd0, 2'd0, C_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd2, 1'b1); tick();
    nop(); tick();
    lit_name = "flush"; lit_wb = 1'b0; lit_mask = lit_mask | 8'h01;
    drive(1'b1, 2'd0, 2'd0, C_MUL, 32'd11, 32'd3, 32'd0, 32'd0, 5'd13, 1'b0); tick();
    drive(1'b1, 2'd0, 2'd0, C_ADD, 32'd100, 32'd1, 32'd0, 32'd0, 5'd14, 1'b1);
    finish_mul();
    flush_in = 1'b0;
    tick();
    expect_res("flush_in_stall", 1'b1, 32'd33, 32'd0, 5'd13);
    nop(); tick();
    expect_res("add_after_flush_stall", 1'b1, 32'd101, 32'd0, 5'd14);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width; all value ports use DATA_W.
REQ-002 Parameter: MUL_ITER, default 32, shift-add iterations per multiply; the value SHALL equal DATA_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wb_en_in  input  1  writeback enable from ID.
REQ-006 mem_signal_in  input  2  [1]=mem read, [0]=mem write, from ID.
REQ-007 branch_type_in  input  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
REQ-008 exe_cmd_in  input  4  ALU command from ID.
REQ-009 val1_in, val2_in, reg2_in, pc_in  input  DATA_W each  operands, store data and PC+4 from ID.
REQ-010 dest_in  input  5  destination register from ID.
REQ-011 flush_in  input  1  inserts a bubble instead of the ID instruction.
REQ-012 br_taken  output  1  branch resolved taken (combinational, to IF and ID).
REQ-013 br_addr  output  DATA_W  branch/jump target (combinational).
REQ-014 stall  output  1  freezes PC, IF/ID and the ID/EXE register while high.
REQ-015 wb_en_out, mem_r_en, mem_w_en  output  1 each  registered control to MEM.
REQ-016 alu_result, st_val  output  DATA_W each  registered result and store data.
REQ-017 dest_out  output  5  registered destination.

Function
REQ-018 Register R1 (ID/EXE) SHALL load the ID inputs each edge unless stall=1, in which case it SHALL hold.
REQ-019 When stall=0 and (flush_in=1 or br_taken=1), R1 SHALL load a bubble: wb_en, mem_signal, branch_type = 0.
REQ-020 stall SHALL take priority over flush_in and br_taken.
REQ-021 ALU on R1 operands: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL, 1001 SRA, 1010 SRL, 1100 MUL; any other code SHALL produce 0.
REQ-022 ADD/SUB SHALL wrap modulo 2^DATA_W; shifts SHALL use val2[4:0]; MUL SHALL return the low DATA_W bits of the unsigned product.
REQ-023 br_addr SHALL equal pc + (val2 << 2) for BEZ/BNE and val2 for JMP.
REQ-024 br_taken SHALL be 1 for BEZ when val1==0, for BNE when val1!=reg2, and always for JMP; otherwise it SHALL be 0.
REQ-025 Register R2 (EXE/MEM) SHALL capture alu_result, reg2 (as st_val), dest and control from R1 one edge after R1 loads, for non-MUL commands.
REQ-026 Multiply FSM states: IDLE, BUSY, DONE.
REQ-027 IDLE -> BUSY when R1 holds MUL with wb_en=1; the transition SHALL load the multiplicand, multiplier and a zero accumulator and reset the iteration counter.
REQ-028 BUSY SHALL perform one shift-add step per cycle and go to DONE after MUL_ITER steps.
REQ-029 DONE -> IDLE unconditionally.
REQ-030 stall SHALL be 1 in the IDLE cycle that detects MUL and in all BUSY cycles (MUL_ITER+1 cycles total), and 0 in DONE.
REQ-031 While stall=1, R2 SHALL load a bubble; in DONE, R2 SHALL capture the product with the MUL control fields.
REQ-032 A MUL bubble (wb_en=0) SHALL NOT start the FSM.
REQ-033 Back-to-back MULs SHALL each take the full sequence; no overlap is allowed.

Reset
REQ-034 rst=1 at an edge SHALL clear R1 and R2 to bubbles, with all data fields 0.
REQ-035 rst=1 at an edge SHALL force the FSM to IDLE, clear the counter and accumulator, and drive stall=0 and br_taken=0 on the next cycle.
REQ-036 rst=1 during BUSY SHALL abort the multiply with no R2 writeback.

Structure
REQ-037 EXE_CMD codes, branch-type codes and MUL FSM state encodings SHALL reside in shared package cpu_pkg.
REQ-038 The shift-add multiplier and its FSM SHALL be sub-module seq_mul (start, operands -> busy, done, product); the ALU and branch logic stay inline.

Verification
REQ-039 ADD: val1=5, val2=7, dest=3, wb_en=1 -> after 2 edges: alu_result=12, dest_out=3, wb_en_out=1.
REQ-040 SUB wrap: val1=0, val2=1 -> alu_result=0xFFFFFFFF.
REQ-041 BNE: val1=4, reg2=5, pc=0x100, val2=3 -> br_taken=1 and br_addr=0x10C in the same cycle; the next R1 load is a bubble.
REQ-042 MUL: val1=6, val2=7 -> stall high for exactly 33 cycles, then R2 holds alu_result=42; the following ADD is delayed by 33 cycles and not lost.
REQ-043 Reset mid-MUL at BUSY cycle 10 -> stall=0 next cycle, wb_en_out=0, FSM IDLE, no result emitted.
REQ-044 flush_in=1 with an ADD on ID inputs -> wb_en_out=0 two edges later; flush_in=1 while stall=1 -> R1 unchanged.
